scale_line_ctrl: RTL and testbench

Line sequencer for the horizontal scaler line buffer. It takes one input line over a valid/ready stream and writes it into the line buffer through the buffer's write port. It then issues the output pixel positions `x_pos` one per cycle and realigns the returning buffer data into an output stream with a valid flag and a last-pixel flag. It sits between the upstream pixel source and the scaling line buffer, which computes each read index as the rounded product of `x_pos` and `x_scale`.

---
 rtl/scale_line_if.sv | 27 ++
 rtl/scale_line_ctrl.sv | 122 ++++++++++++
 tb/tb_scale_line_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/scale_line_if.sv
// Stream, line-buffer write and read-path signals of the scaler line sequencer.
// master: the sequencer side; slave: the pixel source / line buffer side.
interface scale_line_if #(
  parameter int H_LEN = 11
);
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic [10:0]      wr_addr;
  logic [15:0]      wr_data;
  logic             wr_en;
  logic [H_LEN-1:0] x_pos;
  logic [15:0]      rd_data;
  logic             out_valid;
  logic [15:0]      out_data;
  logic             out_last;

  modport master (
    input  in_valid, in_data, rd_data,
    output in_ready, wr_addr, wr_data, wr_en, x_pos, out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_data, rd_data,
    input  in_ready, wr_addr, wr_data, wr_en, x_pos, out_valid, out_data, out_last
  );
endinterface

// File: rtl/scale_line_ctrl.sv
// Line sequencer: fills the scaler line buffer from an input stream, then issues
// output positions and realigns the returning buffer data into an output stream.
module scale_line_ctrl #(
  parameter int H_LEN  = 11,
  parameter int RD_LAT = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [H_LEN-1:0] cfg_in_width,
  input  logic [H_LEN-1:0] cfg_out_width,
  scale_line_if.master     bus,
  output logic             busy,
  output logic             line_done,
  output logic             cfg_err
);

  localparam int FW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [H_LEN-1:0] ONE = H_LEN'(1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, FLUSH} state_t;

  state_t           state, state_n;
  logic [H_LEN-1:0] in_w, out_w, wcnt;
  logic [FW-1:0]    fcnt;
  logic [RD_LAT-1:0] iss_sr, last_sr;
  logic             start_ok, start_rej, accept, issue, issue_last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    start_ok   = 1'b0;
    start_rej  = 1'b0;
    accept     = (state == FILL) && bus.in_valid;
    issue      = (state == DRAIN);
    issue_last = issue && (bus.x_pos == out_w - ONE);
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_in_width != '0 && cfg_out_width != '0) begin
            start_ok = 1'b1;
            state_n  = FILL;
          end else begin
            start_rej = 1'b1;
          end
        end
      end
      FILL:    if (accept && wcnt == in_w - ONE) state_n = DRAIN;
      DRAIN:   if (issue_last) state_n = FLUSH;
      FLUSH:   if (fcnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign bus.in_ready = (state == FILL);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_w          <= '0;
      out_w         <= '0;
      wcnt          <= '0;
      fcnt          <= '0;
      iss_sr        <= '0;
      last_sr       <= '0;
      line_done     <= 1'b0;
      cfg_err       <= 1'b0;
      bus.wr_en     <= 1'b0;
      bus.wr_addr   <= '0;
      bus.wr_data   <= '0;
      bus.x_pos     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      bus.wr_en <= accept;
      line_done <= 1'b0;
      cfg_err   <= 1'b0;

      if (start_ok) begin
        in_w      <= cfg_in_width;
        out_w     <= cfg_out_width;
        wcnt      <= '0;
        bus.x_pos <= '0;
      end
      if (start_rej) begin
        line_done <= 1'b1;
        cfg_err   <= 1'b1;
      end

      if (accept) begin
        bus.wr_addr <= 11'(wcnt);
        bus.wr_data <= bus.in_data;
        wcnt        <= wcnt + ONE;
      end

      // x_pos doubles as the read counter; it parks on the final position.
      if (issue && !issue_last) bus.x_pos <= bus.x_pos + ONE;
      if (issue_last) fcnt <= FW'(RD_LAT);
      if (state == FLUSH) begin
        if (fcnt == '0) line_done <= 1'b1;
        else            fcnt      <= fcnt - FW'(1);
      end

      iss_sr[0]  <= issue;
      last_sr[0] <= issue_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        iss_sr[i]  <= iss_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end

      bus.out_valid <= iss_sr[RD_LAT-1];
      bus.out_last  <= last_sr[RD_LAT-1];
      if (iss_sr[RD_LAT-1]) bus.out_data <= bus.rd_data;
    end
  end

endmodule

// File: tb/tb_scale_line_ctrl.sv
// Directed bench for scale_line_ctrl with a behavioural line buffer and
// scoreboard queues for buffer writes and output beats.
module tb_scale_line_ctrl;
  localparam int H_LEN  = 11;
  localparam int RD_LAT = 3;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [H_LEN-1:0] cfg_iw, cfg_ow;
  logic             busy, line_done, cfg_err;

  scale_line_if #(.H_LEN(H_LEN)) bus ();

  scale_line_ctrl #(.H_LEN(H_LEN), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .cfg_in_width(cfg_iw), .cfg_out_width(cfg_ow),
    .bus(bus),
    .busy(busy), .line_done(line_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] d; logic l; } oexp_t;
  oexp_t       oq[$];
  logic [26:0] wq[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int beats, first_ov, last_cyc;
  int cur_iw = 1, cur_ow = 1;
  logic [15:0] pix [0:63];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx(input int p, input int iw, input int ow);
    int r;
    if (ow == 0) return 0;
    r = (2 * p * iw + ow) / (2 * ow);
    return (r > iw - 1) ? iw - 1 : r;
  endfunction

  // Line buffer model: two multiplier stages then one registered RAM read.
  logic [15:0]      mem [0:2047];
  logic [H_LEN-1:0] xp1, xp2;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    xp1 <= bus.x_pos;
    xp2 <= xp1;
    bus.rd_data <= mem[idx(int'(xp2), cur_iw, cur_ow)];
  end

  always @(negedge clk) begin
    if (rstn && bus.wr_en) begin
      if (wq.size() == 0) check("wr_unexpected", 32'(bus.wr_en), 32'd0);
      else begin
        logic [26:0] e;
        e = wq.pop_front();
        check("wr_addr", 32'(bus.wr_addr), 32'(e[26:16]));
        check("wr_data", 32'(bus.wr_data), 32'(e[15:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && bus.out_valid) begin
      if (oq.size() == 0) check("out_unexpected", 32'(bus.out_valid), 32'd0);
      else begin
        oexp_t e;
        e = oq.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e.d));
        check("out_last", 32'(bus.out_last), 32'(e.l));
      end
      if (beats == 0) first_ov = cyc;
      if (bus.out_last) last_cyc = cyc;
      beats++;
    end
  end

  task automatic run_line(input int iw, input int ow, input int base, input int step,
                          input bit toggle, input bit inject);
    int i, n, k, wa;
    bit v;
    @(negedge clk);
    cur_iw = iw; cur_ow = ow;
    for (int p = 0; p < iw; p++) pix[p] = 16'(base + p * step);
    for (int p = 0; p < ow; p++) oq.push_back('{d: pix[idx(p, iw, ow)], l: (p == ow - 1)});
    beats = 0; first_ov = -100; last_cyc = -100;
    start = 1'b1; cfg_iw = H_LEN'(iw); cfg_ow = H_LEN'(ow);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(bus.in_ready), 32'd1);
    i = 0; n = 0; k = 0; wa = 0; v = 1'b1;
    while (i < iw && n < 100) begin
      bus.in_valid = v;
      bus.in_data  = pix[i];
      if (v && bus.in_ready) begin
        wq.push_back({11'(wa), pix[i]});
        wa++; k = cyc; i++;
      end
      if (toggle) v = ~v;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    check("accept_count", 32'(i), 32'(iw));
    check("in_ready_drop", 32'(bus.in_ready), 32'd0);
    if (inject) begin
      start = 1'b1; cfg_iw = 11'd7; cfg_ow = 11'd2;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!line_done && n < 300);
    check("line_done_seen", 32'(line_done), 32'd1);
    check("line_done_cfg_err", 32'(cfg_err), 32'd0);
    check("line_done_busy", 32'(busy), 32'd0);
    check("line_done_timing", 32'(cyc - last_cyc), 32'd1);
    check("beat_count", 32'(beats), 32'(ow));
    check("first_beat_latency", 32'(first_ov - k), 32'(RD_LAT + 2));
    check("burst_contiguous", 32'(last_cyc - first_ov), 32'(ow - 1));
    check("out_queue_empty", 32'(oq.size()), 32'd0);
    check("wr_queue_empty", 32'(wq.size()), 32'd0);
  endtask

  task automatic reject_line(input int iw, input int ow);
    @(negedge clk);
    beats = 0;
    start = 1'b1; cfg_iw = H_LEN'(iw); cfg_ow = H_LEN'(ow);
    @(negedge clk);
    start = 1'b0;
    check("rej_line_done", 32'(line_done), 32'd1);
    check("rej_cfg_err", 32'(cfg_err), 32'd1);
    check("rej_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rej_line_done_clear", 32'(line_done), 32'd0);
    check("rej_cfg_err_clear", 32'(cfg_err), 32'd0);
    repeat (8) @(negedge clk);
    check("rej_no_output", 32'(beats), 32'd0);
    check("rej_busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0; start = 1'b0; cfg_iw = '0; cfg_ow = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    beats = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_x_pos", 32'(bus.x_pos), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    rstn = 1'b1;

    // Reset after five accepts of an eight-pixel line.
    @(negedge clk);
    start = 1'b1; cfg_iw = 11'd8; cfg_ow = 11'd4;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int p = 0; p < 5; p++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h0a00 + p);
      if (bus.in_ready) begin
        wq.push_back({11'(n), 16'(16'h0a00 + p)});
        n++;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("midfill_accepts", 32'(n), 32'd5);
    check("midfill_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("midrst_wr_data", 32'(bus.wr_data), 32'd0);
    check("midrst_x_pos", 32'(bus.x_pos), 32'd0);
    wq.delete();
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_line_done", 32'(line_done), 32'd0);
    end

    run_line(4, 8, 10, 10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    run_line(4, 4, 16'h0100, 3, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    reject_line(0, 5);
    reject_line(3, 0);
    run_line(3, 6, 16'h2000, 17, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    run_line(3, 5, 16'h3000, 5, 1'b0, 1'b0);
    run_line(6, 2, 16'h4000, 9, 1'b0, 1'b0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
